// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package regfile_pkg;

    localparam int unsigned NREG   = 8;
    localparam int unsigned ADDR_W = 3;
    localparam logic [ADDR_W-1:0] R7_ADDR = 3'd7;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant selection with a 1-bit fairness pointer.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic    clock,
    input  logic    rst,
    input  logic    alu_valid,
    input  logic    mem_valid,
    input  logic    stall,
    output logic    alu_ready,
    output logic    mem_ready,
    output logic    accept,
    output req_id_e grant
);

    logic rr_q;

    // A lone requester wins regardless of the pointer.
    always_comb begin
        grant = REQ_ALU;
        if (alu_valid && mem_valid) begin
            grant = rr_q ? REQ_MEM : REQ_ALU;
        end else if (mem_valid) begin
            grant = REQ_MEM;
        end
    end

    assign alu_ready = rst && !stall && alu_valid && (grant == REQ_ALU);
    assign mem_ready = rst && !stall && mem_valid && (grant == REQ_MEM);
    assign accept    = alu_ready || mem_ready;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            rr_q <= 1'b0;
        end else if (accept) begin
            rr_q <= (grant == REQ_ALU);
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates ALU and load writebacks onto one register-file write port.
// Optional busy scoreboard enabled by defining RFARB_SCOREBOARD_EN.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [W-1:0]      alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [W-1:0]      mem_data,
    input  logic              stall,
`ifdef RFARB_SCOREBOARD_EN
    input  logic              reserve_valid,
    input  logic [ADDR_W-1:0] reserve_addr,
    output logic [NREG-1:0]   busy,
`endif
    output logic [ADDR_W-1:0] A3,
    output logic [W-1:0]      WD3,
    output logic              enable,
    output logic              err_r7
);

    logic              accept;
    req_id_e           grant;
    logic [ADDR_W-1:0] acc_addr;
    logic [W-1:0]      acc_data;
    logic              wr_fire;

    rr_arbiter2 u_arb (
        .clock     (clock),
        .rst       (rst),
        .alu_valid (alu_valid),
        .mem_valid (mem_valid),
        .stall     (stall),
        .alu_ready (alu_ready),
        .mem_ready (mem_ready),
        .accept    (accept),
        .grant     (grant)
    );

    assign acc_addr = (grant == REQ_MEM) ? mem_addr : alu_addr;
    assign acc_data = (grant == REQ_MEM) ? mem_data : alu_data;
    // R7 is owned by another port: accepted but never written here.
    assign wr_fire  = accept && (acc_addr != R7_ADDR);

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            enable <= 1'b0;
            A3     <= '0;
            WD3    <= '0;
            err_r7 <= 1'b0;
        end else begin
            enable <= wr_fire;
            err_r7 <= accept && (acc_addr == R7_ADDR);
            if (wr_fire) begin
                A3  <= acc_addr;
                WD3 <= acc_data;
            end
        end
    end

`ifdef RFARB_SCOREBOARD_EN
    logic [NREG-1:0] busy_d;

    // Set is applied after clear so a same-edge reserve wins.
    always_comb begin
        busy_d = busy;
        if (wr_fire) begin
            busy_d[acc_addr] = 1'b0;
        end
        if (reserve_valid && (reserve_addr != R7_ADDR)) begin
            busy_d[reserve_addr] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= busy_d;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench: directed vector table, hand sequences, random traffic vs a model.
module tb_regfile_wr_arbiter;
    import regfile_pkg::*;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         rst = 1'b0;
    logic         alu_valid, alu_ready, mem_valid, mem_ready, stall;
    logic [2:0]   alu_addr, mem_addr, A3;
    logic [W-1:0] alu_data, mem_data, WD3;
    logic         enable, err_r7;
`ifdef RFARB_SCOREBOARD_EN
    logic         reserve_valid;
    logic [2:0]   reserve_addr;
    logic [7:0]   busy;
`endif

    always #5 clock = ~clock;

    regfile_wr_arbiter #(.W(W)) dut (
        .clock         (clock),
        .rst           (rst),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_addr      (alu_addr),
        .alu_data      (alu_data),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .stall         (stall),
`ifdef RFARB_SCOREBOARD_EN
        .reserve_valid (reserve_valid),
        .reserve_addr  (reserve_addr),
        .busy          (busy),
`endif
        .A3            (A3),
        .WD3           (WD3),
        .enable        (enable),
        .err_r7        (err_r7)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: who was served last, and what the port should show now.
    logic         m_favor_mem;
    logic         m_en;
    logic [2:0]   m_a3;
    logic [W-1:0] m_wd3;
    logic         m_err;
    logic [7:0]   m_busy;
    int           last_win;

    task automatic model_reset();
        m_favor_mem = 1'b0;
        m_en = 1'b0;
        m_a3 = '0;
        m_wd3 = '0;
        m_err = 1'b0;
        m_busy = '0;
        last_win = 0;
    endtask

    // 0 = nobody, 1 = ALU, 2 = MEM
    function automatic int winner();
        if (stall || !rst) return 0;
        if (alu_valid && mem_valid) return m_favor_mem ? 2 : 1;
        if (alu_valid) return 1;
        if (mem_valid) return 2;
        return 0;
    endfunction

    task automatic model_edge();
        int w;
        logic [2:0] a;
        logic [W-1:0] d;
        w = winner();
        last_win = w;
        if (!rst) begin
            model_reset();
            return;
        end
        m_en = 1'b0;
        m_err = 1'b0;
        if (w != 0) begin
            a = (w == 1) ? alu_addr : mem_addr;
            d = (w == 1) ? alu_data : mem_data;
            m_favor_mem = (w == 1);
            if (a == 3'd7) begin
                m_err = 1'b1;
            end else begin
                m_en = 1'b1;
                m_a3 = a;
                m_wd3 = d;
                m_busy[a] = 1'b0;
            end
        end
`ifdef RFARB_SCOREBOARD_EN
        if (reserve_valid && reserve_addr != 3'd7) m_busy[reserve_addr] = 1'b1;
`endif
    endtask

    task automatic check_model(input string tag);
        int w;
        w = winner();
        check({tag, ".alu_ready"}, 32'(alu_ready), 32'(w == 1));
        check({tag, ".mem_ready"}, 32'(mem_ready), 32'(w == 2));
        check({tag, ".enable"}, 32'(enable), 32'(m_en));
        check({tag, ".A3"}, 32'(A3), 32'(m_a3));
        check({tag, ".WD3"}, 32'(WD3), 32'(m_wd3));
        check({tag, ".err_r7"}, 32'(err_r7), 32'(m_err));
`ifdef RFARB_SCOREBOARD_EN
        check({tag, ".busy"}, 32'(busy), 32'(m_busy));
`endif
    endtask

    // Inputs are driven 1 time unit after posedge; outputs are checked on negedge.
    task automatic cycle(input string tag);
        @(negedge clock);
        check_model(tag);
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_addr = 0; alu_data = 0;
        mem_valid = 0; mem_addr = 0; mem_data = 0;
        stall = 0;
`ifdef RFARB_SCOREBOARD_EN
        reserve_valid = 0; reserve_addr = 0;
`endif
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        rst = 1'b1;
    endtask

    typedef struct {
        logic       st;
        logic       av;
        logic [2:0] aa;
        logic [7:0] ad;
        logic       mv;
        logic [2:0] ma;
        logic [7:0] md;
        logic       ar;
        logic       mr;
        logic       en;
        logic [2:0] a3;
        logic [7:0] wd3;
        logic       err;
    } vec_t;

    vec_t vecs[14];

    initial begin
        //          st av aa    ad     mv ma    md     ar mr en a3    wd3    err
        vecs[0]  = '{0, 1, 3'd1, 8'h11, 1, 3'd2, 8'h22, 1, 0, 0, 3'd0, 8'h00, 0};
        vecs[1]  = '{0, 0, 3'd0, 8'h00, 1, 3'd2, 8'h22, 0, 1, 1, 3'd1, 8'h11, 0};
        vecs[2]  = '{0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 0, 1, 3'd2, 8'h22, 0};
        vecs[3]  = '{0, 1, 3'd3, 8'h5A, 0, 3'd0, 8'h00, 1, 0, 0, 3'd2, 8'h22, 0};
        vecs[4]  = '{0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 0, 1, 3'd3, 8'h5A, 0};
        vecs[5]  = '{0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 0, 0, 3'd3, 8'h5A, 0};
        vecs[6]  = '{0, 0, 3'd0, 8'h00, 1, 3'd7, 8'hFF, 0, 1, 0, 3'd3, 8'h5A, 0};
        vecs[7]  = '{0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 0, 0, 3'd3, 8'h5A, 1};
        vecs[8]  = '{1, 1, 3'd5, 8'h33, 0, 3'd0, 8'h00, 0, 0, 0, 3'd3, 8'h5A, 0};
        vecs[9]  = '{1, 1, 3'd5, 8'h33, 0, 3'd0, 8'h00, 0, 0, 0, 3'd3, 8'h5A, 0};
        vecs[10] = '{1, 1, 3'd5, 8'h33, 0, 3'd0, 8'h00, 0, 0, 0, 3'd3, 8'h5A, 0};
        vecs[11] = '{0, 1, 3'd5, 8'h33, 0, 3'd0, 8'h00, 1, 0, 0, 3'd3, 8'h5A, 0};
        vecs[12] = '{0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 0, 1, 3'd5, 8'h33, 0};
        vecs[13] = '{0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 0, 0, 3'd5, 8'h33, 0};

        idle_inputs();
        model_reset();
        #2;
        check("reset.enable", 32'(enable), 32'd0);
        check("reset.A3", 32'(A3), 32'd0);
        check("reset.WD3", 32'(WD3), 32'd0);
        check("reset.err_r7", 32'(err_r7), 32'd0);
        alu_valid = 1; mem_valid = 1;
        #1;
        check("reset.alu_ready", 32'(alu_ready), 32'd0);
        check("reset.mem_ready", 32'(mem_ready), 32'd0);
        idle_inputs();
        do_reset();

        // Directed vectors
        for (int i = 0; i < 14; i++) begin
            stall = vecs[i].st;
            alu_valid = vecs[i].av; alu_addr = vecs[i].aa; alu_data = vecs[i].ad;
            mem_valid = vecs[i].mv; mem_addr = vecs[i].ma; mem_data = vecs[i].md;
            @(negedge clock);
            check($sformatf("vec%0d.alu_ready", i), 32'(alu_ready), 32'(vecs[i].ar));
            check($sformatf("vec%0d.mem_ready", i), 32'(mem_ready), 32'(vecs[i].mr));
            check($sformatf("vec%0d.enable", i), 32'(enable), 32'(vecs[i].en));
            check($sformatf("vec%0d.A3", i), 32'(A3), 32'(vecs[i].a3));
            check($sformatf("vec%0d.WD3", i), 32'(WD3), 32'(vecs[i].wd3));
            check($sformatf("vec%0d.err_r7", i), 32'(err_r7), 32'(vecs[i].err));
            model_edge();
            @(posedge clock);
            #1;
        end
        idle_inputs();

        // Both held valid for 6 cycles: grants must alternate starting with ALU
        do_reset();
        alu_valid = 1; alu_addr = 3'd1; alu_data = 8'hA0;
        mem_valid = 1; mem_addr = 3'd2; mem_data = 8'hB0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check($sformatf("alt%0d.alu_ready", i), 32'(alu_ready), 32'(i % 2 == 0));
            check($sformatf("alt%0d.mem_ready", i), 32'(mem_ready), 32'(i % 2 == 1));
            if (i > 0) begin
                check($sformatf("alt%0d.enable", i), 32'(enable), 32'd1);
                check($sformatf("alt%0d.A3", i), 32'(A3), (i % 2 == 1) ? 32'd1 : 32'd2);
            end
            model_edge();
            @(posedge clock);
            #1;
        end
        idle_inputs();
        cycle("alt_tail");

        // Reset asserted while a write is in flight
        alu_valid = 1; alu_addr = 3'd2; alu_data = 8'h44;
        cycle("inflight_accept");
        alu_valid = 0;
        check("inflight.enable_before", 32'(enable), 32'd1);
        rst = 1'b0;
        model_reset();
        #1;
        check("inflight.enable_rst", 32'(enable), 32'd0);
        check("inflight.A3_rst", 32'(A3), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cycle("after_rst");

`ifdef RFARB_SCOREBOARD_EN
        reserve_valid = 1; reserve_addr = 3'd4;
        cycle("sb_reserve");
        reserve_valid = 0;
        @(negedge clock);
        check("sb.busy4_set", 32'(busy[4]), 32'd1);
        @(posedge clock);
        #1;
        alu_valid = 1; alu_addr = 3'd4; alu_data = 8'h99;
        reserve_valid = 1; reserve_addr = 3'd4;
        cycle("sb_setclear");
        alu_valid = 0; reserve_valid = 0;
        @(negedge clock);
        check("sb.busy4_setwins", 32'(busy[4]), 32'd1);
        @(posedge clock);
        #1;
        alu_valid = 1; alu_addr = 3'd4; alu_data = 8'h98;
        cycle("sb_clear");
        alu_valid = 0;
        @(negedge clock);
        check("sb.busy4_clear", 32'(busy[4]), 32'd0);
        @(posedge clock);
        #1;
        reserve_valid = 1; reserve_addr = 3'd7;
        cycle("sb_r7");
        reserve_valid = 1; reserve_addr = 3'd2;
        alu_valid = 1; alu_addr = 3'd3; alu_data = 8'h12;
        cycle("sb_pre_rst");
        idle_inputs();
        check("sb.r7_ignored", 32'(busy[7]), 32'd0);
        rst = 1'b0;
        model_reset();
        #1;
        check("sb.busy_rst", 32'(busy), 32'd0);
        check("sb.enable_rst", 32'(enable), 32'd0);
        @(posedge clock);
        #1;
        rst = 1'b1;
`endif

        // Random traffic; requesters hold until accepted
        idle_inputs();
        for (int n = 0; n < 400; n++) begin
            if (!alu_valid || last_win == 1) begin
                alu_valid = ($urandom_range(0, 1) == 1);
                alu_addr = 3'($urandom_range(0, 7));
                alu_data = 8'($urandom);
            end
            if (!mem_valid || last_win == 2) begin
                mem_valid = ($urandom_range(0, 1) == 1);
                mem_addr = 3'($urandom_range(0, 7));
                mem_data = 8'($urandom);
            end
            stall = ($urandom_range(0, 3) == 0);
`ifdef RFARB_SCOREBOARD_EN
            reserve_valid = ($urandom_range(0, 2) == 0);
            reserve_addr = 3'($urandom_range(0, 7));
`endif
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have parameter: W, 8, data width of the register-file write port.
REQ-002 SHALL have port: clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: alu_valid input 1, alu_ready output 1, alu_addr input 3, alu_data input W; ALU writeback requester.
REQ-005 SHALL have ports: mem_valid input 1, mem_ready output 1, mem_addr input 3, mem_data input W; load writeback requester.
REQ-006 SHALL have port: stall  input  1  when high, blocks all grants.
REQ-007 SHALL have ports: A3 output 3, WD3 output W, enable output 1; these drive the register-file write port.
REQ-008 SHALL have port: err_r7  output  1  one-cycle pulse when a write to address 7 is dropped.
REQ-009 SHALL have ports, only when RFARB_SCOREBOARD_EN is defined: reserve_valid input 1, reserve_addr input 3, busy output 8.

Function
REQ-010 SHALL accept at most one request per cycle; a request is accepted when valid and ready are both high.
REQ-011 SHALL compute ready combinationally: stall=1 forces both readies low; otherwise only the granted requester's ready is high.
REQ-012 SHALL grant the sole valid requester when only one is valid, regardless of the round-robin pointer.
REQ-013 SHALL grant by a 1-bit round-robin pointer rr when both requesters are valid: rr=0 grants ALU, rr=1 grants MEM.
REQ-014 SHALL set rr to favour the non-granted requester after every accepted request; rr holds when nothing is accepted.
REQ-015 SHALL require requesters to hold valid, addr and data stable until accepted; a non-accepted request is never lost.
REQ-016 SHALL register the accepted request: enable=1 with A3/WD3 equal to the accepted addr/data for exactly the next cycle (latency 1).
REQ-017 SHALL set enable=0 in any cycle following a cycle with no acceptance; A3 and WD3 hold their last values.
REQ-018 SHALL accept a request with addr=7 (R7/PC is owned by a separate port) without driving enable, and pulse err_r7 for the next cycle.
REQ-019 SHALL support back-to-back acceptances, giving one enable per cycle with no bubble.
REQ-020 SHALL take effect on stall in the same cycle; a request already registered for output still completes its enable cycle.

Reset
REQ-021 SHALL, while rst=0, force enable=0, A3=0, WD3=0, err_r7=0, rr=0 and busy=0, and drive readies low.
REQ-022 SHALL discard any request that is in flight when reset is asserted mid-operation, issuing no enable after reset is released.

Configuration
REQ-023 SHALL, with RFARB_SCOREBOARD_EN defined, set busy[reserve_addr] on the edge where reserve_valid=1.
REQ-024 SHALL, with RFARB_SCOREBOARD_EN defined, clear busy[a] on the edge that registers the enable write to a.
REQ-025 SHALL, with RFARB_SCOREBOARD_EN defined, let the set win when a reserve and a clear hit the same address on the same edge.
REQ-026 SHALL, with RFARB_SCOREBOARD_EN defined, ignore a reserve of address 7.
REQ-027 SHALL, without RFARB_SCOREBOARD_EN, omit the scoreboard ports and logic; all other behaviour is unchanged.

Structure
REQ-028 SHALL take the following from shared package regfile_pkg: NREG=8, ADDR_W=3, R7_ADDR=3'd7, and the requester-id enum (REQ_ALU, REQ_MEM).
REQ-029 SHALL implement grant selection and the rr pointer in sub-module rr_arbiter2; the output register, error pulse and scoreboard stay in the top module.

Verification
REQ-030 SHALL cover: ALU only, addr=3, data=8'h5A -> alu_ready=1 that cycle; next cycle enable=1, A3=3, WD3=8'h5A; following cycle enable=0.
REQ-031 SHALL cover: both valid after reset, ALU addr=1 data=8'h11 and MEM addr=2 data=8'h22 held -> ALU granted first, MEM next cycle; enables to 1 then 2 on consecutive cycles.
REQ-032 SHALL cover: both held valid continuously for 6 cycles -> grants alternate ALU, MEM, ALU, MEM, ALU, MEM.
REQ-033 SHALL cover: MEM addr=7 data=8'hFF -> accepted; next cycle err_r7=1 and enable=0.
REQ-034 SHALL cover: stall=1 for 3 cycles with ALU valid -> alu_ready=0 and enable=0 throughout; the ALU write issues 1 cycle after stall drops.
REQ-035 SHALL cover, with RFARB_SCOREBOARD_EN: reserve 4, then ALU write to 4, with a same-edge reserve of 4 -> busy[4]=1 after reserve, still 1 after the simultaneous set/clear, then 0 after an unreserved write to 4; rst=0 mid-write -> busy=0 and enable=0.
